read_port_server: RTL and testbench



---
 rtl/read_port_server.sv | 132 +++++++++++++
 tb/tb_read_port_server.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/read_port_server.sv
// Memory-side responder for the accelerator wrapper's read channel: fetches one
// word per request from a fixed-latency memory and returns it with a read_ready pulse.
module read_port_server #(
  parameter int unsigned MEM_AW     = 16,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned ADDR_SHIFT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_enable,
  input  logic              finish_read,
  input  logic [63:0]       read_addr,
  input  logic [63:0]       read_size,
  output logic [63:0]       read_ready,
  output logic [31:0]       read_data,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              busy,
  output logic [31:0]       words_served,
  output logic              stride_err
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_ACK} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic              aborted, aborted_d;
  logic              ready_q, ready_d;
  logic [31:0]       data_d;
  logic              rd_en_d;
  logic [MEM_AW-1:0] addr_d;
  logic [31:0]       ws_d;
  logic              serr_d;
  logic [MEM_AW-1:0] req_word;
  logic              fetch_done;
  logic              deliver;
  logic              unused_addr;

  // Bits outside the word-address slice are deliberately ignored (index wraps).
  assign req_word    = read_addr[ADDR_SHIFT+MEM_AW-1:ADDR_SHIFT];
  assign unused_addr = ^{read_addr[63:ADDR_SHIFT+MEM_AW], read_addr[ADDR_SHIFT-1:0]};

  // An abort seen at any point in FETCH, or at the final cycle, drops the word.
  assign fetch_done = (state == FETCH) && (cnt == CW'(0));
  assign deliver    = fetch_done && !aborted && read_enable;

  assign read_ready = {63'd0, ready_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      aborted      <= 1'b0;
      ready_q      <= 1'b0;
      read_data    <= '0;
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      busy         <= 1'b0;
      words_served <= '0;
      stride_err   <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      aborted      <= aborted_d;
      ready_q      <= ready_d;
      read_data    <= data_d;
      mem_rd_en    <= rd_en_d;
      mem_addr     <= addr_d;
      busy         <= (state_d != IDLE);
      words_served <= ws_d;
      stride_err   <= serr_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (read_enable) state_d = FETCH;
      FETCH:    if (fetch_done) state_d = deliver ? WAIT_ACK : IDLE;
      WAIT_ACK: begin
        if (finish_read)       state_d = FETCH;
        else if (!read_enable) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt;
    aborted_d = aborted;
    ready_d   = 1'b0;
    data_d    = read_data;
    rd_en_d   = 1'b0;
    addr_d    = mem_addr;
    ws_d      = words_served;
    serr_d    = stride_err;
    case (state)
      IDLE: begin
        if (read_enable) begin
          rd_en_d   = 1'b1;
          addr_d    = req_word;
          cnt_d     = CW'(MEM_LAT);
          aborted_d = 1'b0;
          if (read_size != 64'd4) serr_d = 1'b1;
        end
      end
      FETCH: begin
        if (!read_enable) aborted_d = 1'b1;
        if (cnt != CW'(0)) begin
          cnt_d = cnt - CW'(1);
        end else if (deliver) begin
          ready_d = 1'b1;
          data_d  = mem_rd_data;
          ws_d    = words_served + 32'd1;
        end
      end
      WAIT_ACK: begin
        if (finish_read) begin
          rd_en_d   = 1'b1;
          addr_d    = req_word;
          cnt_d     = CW'(MEM_LAT);
          aborted_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_read_port_server.sv
// Self-checking bench for read_port_server with a behavioural pipelined memory
// and a wrapper model driving randomized hold times and addresses.
module tb_read_port_server;

  localparam int unsigned LAT = 2;
  localparam int unsigned AW  = 16;

  logic          clk = 1'b0;
  logic          reset, read_enable, finish_read;
  logic [63:0]   read_addr, read_size, read_ready;
  logic [31:0]   read_data, mem_rd_data, words_served;
  logic          mem_rd_en, busy, stride_err;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int passed = 0;
  int ws_model = 0;

  logic [31:0] mem [0:65535];
  logic [31:0] pipe [LAT];
  logic        prev_ready = 1'b0;

  always #5 clk = ~clk;

  read_port_server #(.MEM_AW(AW), .MEM_LAT(LAT), .ADDR_SHIFT(2)) dut (
    .clk(clk), .reset(reset), .read_enable(read_enable), .finish_read(finish_read),
    .read_addr(read_addr), .read_size(read_size), .read_ready(read_ready),
    .read_data(read_data), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .busy(busy), .words_served(words_served),
    .stride_err(stride_err)
  );

  // Memory returns data LAT cycles after the strobe cycle; garbage when not strobed.
  always @(posedge clk) begin
    pipe[0] <= (mem_rd_en === 1'b1) ? mem[mem_addr] : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rd_data = pipe[LAT-1];

  // read_ready must be a lone pulse with upper bits zero.
  always @(negedge clk) begin
    if (read_ready[0] === 1'b1) begin
      checks++;
      if (prev_ready || read_ready[63:1] !== 63'd0)
        $display("FAIL ready_pulse: prev=%0b upper=%h required single pulse, upper 0", prev_ready, read_ready[63:1]);
      else passed++;
    end
    prev_ready = (read_ready[0] === 1'b1);
  end

  function automatic logic [AW-1:0] widx(input logic [63:0] a);
    return a[AW+1:2];
  endfunction

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (read_ready[0] !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic issue(input logic [63:0] a);
    read_addr   = a;
    read_enable = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; read_enable = 1'b0; finish_read = 1'b0; read_addr = '0; read_size = 64'd4;
    repeat (2) @(negedge clk);
    checks++; if (read_ready !== 64'd0) $display("FAIL rst_ready: got %h want 0", read_ready); else passed++;
    checks++; if (read_data !== 32'd0) $display("FAIL rst_data: got %h want 0", read_data); else passed++;
    checks++; if ({mem_rd_en, mem_addr} !== '0) $display("FAIL rst_mem: en=%b addr=%h want 0", mem_rd_en, mem_addr); else passed++;
    checks++; if ({busy, stride_err} !== 2'b00) $display("FAIL rst_flags: busy=%b serr=%b want 0", busy, stride_err); else passed++;
    checks++; if (words_served !== 32'd0) $display("FAIL rst_ws: got %0d want 0", words_served); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int cyc;
    mem[16'h10] = 32'hDEAD_BEEF;
    issue(64'h40);
    @(negedge clk);
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h10 || busy !== 1'b1)
      $display("FAIL single_issue: en=%b addr=%h busy=%b want 1/0010/1", mem_rd_en, mem_addr, busy); else passed++;
    wait_ready(cyc);
    checks++; if (cyc != LAT + 1) $display("FAIL single_latency: got %0d want %0d", cyc, LAT + 1); else passed++;
    checks++; if (read_data !== 32'hDEAD_BEEF) $display("FAIL single_data: got %h want deadbeef", read_data); else passed++;
    checks++; if (read_ready !== 64'd1) $display("FAIL single_ready: got %h want 1", read_ready); else passed++;
    ws_model++;
    read_enable = 1'b0;
    @(negedge clk);
    checks++; if (read_ready[0] !== 1'b0 || busy !== 1'b0) $display("FAIL single_idle: ready=%b busy=%b want 0/0", read_ready[0], busy); else passed++;
    checks++; if (words_served !== 32'(ws_model)) $display("FAIL single_ws: got %0d want %0d", words_served, ws_model); else passed++;
  endtask

  task automatic test_burst;
    int cyc, holds;
    for (int i = 0; i < 128; i++) mem[16'h400 + 16'(i)] = 32'(i * 3);
    issue(64'h1000);
    @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      wait_ready(cyc);
      checks++; if (cyc != LAT + 1) $display("FAIL burst_latency[%0d]: got %0d want %0d", i, cyc, LAT + 1); else passed++;
      checks++; if (read_data !== 32'(i * 3)) $display("FAIL burst_data[%0d]: got %0d want %0d", i, read_data, i * 3); else passed++;
      ws_model++;
      if (i == 127) break;
      holds = int'($urandom_range(0, 2));
      repeat (holds) @(negedge clk);
      finish_read = 1'b1;
      read_addr   = 64'h1000 + 64'(4 * (i + 1));
      @(negedge clk);
      finish_read = 1'b0;
      checks++; if (mem_rd_en !== 1'b1 || mem_addr !== widx(read_addr))
        $display("FAIL burst_issue[%0d]: en=%b addr=%h want 1/%h", i, mem_rd_en, mem_addr, widx(read_addr)); else passed++;
    end
    read_enable = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL burst_busy: got %b want 0", busy); else passed++;
    checks++; if (words_served !== 32'(ws_model)) $display("FAIL burst_ws: got %0d want %0d", words_served, ws_model); else passed++;
  endtask

  task automatic test_abort;
    int cyc, pulses;
    logic [63:0] a;
    logic [31:0] v;
    a = {48'd0, 16'($urandom_range(0, 16'hFFF0))};
    issue(a);
    @(negedge clk);
    read_enable = 1'b0;
    pulses = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (read_ready[0] === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) $display("FAIL abort_pulses: got %0d want 0", pulses); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
    checks++; if (words_served !== 32'(ws_model)) $display("FAIL abort_ws: got %0d want %0d", words_served, ws_model); else passed++;
    v = $urandom;
    a = a + 64'd4;
    mem[widx(a)] = v;
    issue(a);
    @(negedge clk);
    wait_ready(cyc);
    checks++; if (cyc != LAT + 1 || read_data !== v)
      $display("FAIL abort_next: lat=%0d data=%h want %0d/%h", cyc, read_data, LAT + 1, v); else passed++;
    ws_model++;
    read_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stride_wrap;
    int cyc;
    logic [63:0] a;
    logic [31:0] v;
    mem[0] = 32'hA5A5_0001;
    read_size = 64'd8;
    issue(64'h40000);
    @(negedge clk);
    read_size = 64'd4;
    checks++; if (mem_addr !== 16'h0000) $display("FAIL wrap_addr: got %h want 0000", mem_addr); else passed++;
    checks++; if (stride_err !== 1'b1) $display("FAIL stride_set: got %b want 1", stride_err); else passed++;
    wait_ready(cyc);
    checks++; if (read_data !== 32'hA5A5_0001) $display("FAIL wrap_data: got %h want a5a50001", read_data); else passed++;
    ws_model++;
    read_enable = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      a = {$urandom, $urandom};
      v = $urandom;
      mem[widx(a)] = v;
      issue(a);
      @(negedge clk);
      checks++; if (mem_addr !== widx(a)) $display("FAIL rand_addr[%0d]: got %h want %h", k, mem_addr, widx(a)); else passed++;
      wait_ready(cyc);
      checks++; if (read_data !== v) $display("FAIL rand_data[%0d]: got %h want %h", k, read_data, v); else passed++;
      checks++; if (stride_err !== 1'b1) $display("FAIL stride_sticky[%0d]: got %b want 1", k, stride_err); else passed++;
      ws_model++;
      read_enable = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_simultaneous;
    int cyc;
    logic [63:0] a, b;
    logic [31:0] va, vb;
    a = 64'h2000; b = 64'h3000 + 64'({$urandom_range(0, 255), 2'b00});
    va = $urandom; vb = $urandom;
    mem[widx(a)] = va; mem[widx(b)] = vb;
    issue(a);
    @(negedge clk);
    wait_ready(cyc);
    checks++; if (read_data !== va) $display("FAIL simul_first: got %h want %h", read_data, va); else passed++;
    ws_model++;
    finish_read = 1'b1; read_enable = 1'b0; read_addr = b;
    @(negedge clk);
    finish_read = 1'b0; read_enable = 1'b1;
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== widx(b) || busy !== 1'b1)
      $display("FAIL simul_issue: en=%b addr=%h busy=%b want 1/%h/1", mem_rd_en, mem_addr, busy, widx(b)); else passed++;
    wait_ready(cyc);
    checks++; if (cyc != LAT + 1 || read_data !== vb)
      $display("FAIL simul_second: lat=%0d data=%h want %0d/%h", cyc, read_data, LAT + 1, vb); else passed++;
    ws_model++;
    read_enable = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || words_served !== 32'(ws_model))
      $display("FAIL simul_end: busy=%b ws=%0d want 0/%0d", busy, words_served, ws_model); else passed++;
  endtask

  task automatic test_reset_fetch;
    int pulses;
    issue(64'h80);
    @(negedge clk);
    reset = 1'b1; read_enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ws_model = 0;
    checks++; if (read_ready !== 64'd0 || read_data !== 32'd0) $display("FAIL rstf_out: ready=%h data=%h want 0/0", read_ready, read_data); else passed++;
    checks++; if ({mem_rd_en, mem_addr, busy, stride_err} !== '0)
      $display("FAIL rstf_ctl: en=%b addr=%h busy=%b serr=%b want 0", mem_rd_en, mem_addr, busy, stride_err); else passed++;
    checks++; if (words_served !== 32'd0) $display("FAIL rstf_ws: got %0d want 0", words_served); else passed++;
    pulses = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (read_ready[0] === 1'b1) pulses++;
    end
    checks++; if (pulses != 0 || busy !== 1'b0) $display("FAIL rstf_quiet: pulses=%0d busy=%b want 0/0", pulses, busy); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_abort;
    test_stride_wrap;
    test_simultaneous;
    test_reset_fetch;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
